clk_div_multi: RTL

Parametrised, multi-channel, programmable clock-enable divider. It is the successor to the fixed divide-by-16 250 Hz conditioner. Each of NCH channels divides CLK by a runtime-loadable ratio and produces a registered near-50%-duty output with rise/fall strobes. Divisor changes are glitch-free: they take effect only at a period boundary. The block sits between the system clock and the slow-peripheral timing logic (scan, debounce, display refresh).

---
 rtl/clk_div_pkg.sv | 10 +
 rtl/clk_div_chan.sv | 86 ++++++++
 rtl/clk_div_multi.sv | 55 +++++
 3 files changed

// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the multi-channel programmable clock divider.
package clk_div_pkg;
    localparam int DIV_RST_DEF = 16;
    localparam int DIV_MIN     = 2;

    // Length of the low phase; odd ratios give the extra cycle to the low phase.
    function automatic int unsigned lo_of(input int unsigned div);
        return div - (div >> 1);
    endfunction
endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: counter, active/pending divisor, output and edge strobes.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int W       = 8,
    parameter int DIV_RST = DIV_RST_DEF
) (
    input  logic         CLK,
    input  logic         RESET,
    input  logic         en,
    input  logic         wr,
    input  logic [W-1:0] wr_div,
    output logic         busy,
    output logic         clk_out,
    output logic         rise,
    output logic         fall
);
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] div_q, div_d;
    logic [W-1:0] pend_q, pend_d;
    logic         pend_vld_q, pend_vld_d;
    logic         out_q, out_d;
    logic         rise_q, rise_d;
    logic         fall_q, fall_d;
    logic         wrap;

    assign wrap = (cnt_q == div_q - W'(1));

    always_comb begin
        cnt_d      = cnt_q;
        div_d      = div_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        out_d      = out_q;
        rise_d     = 1'b0;
        fall_d     = 1'b0;
        if (!en) begin
            // Idle channel: a write restarts it cleanly from the low phase.
            if (wr) begin
                div_d      = wr_div;
                cnt_d      = '0;
                out_d      = 1'b0;
                pend_vld_d = 1'b0;
            end
        end else begin
            cnt_d = wrap ? '0 : cnt_q + W'(1);
            if (wrap) begin
                if (wr)              div_d = wr_div;
                else if (pend_vld_q) div_d = pend_q;
                pend_vld_d = 1'b0;
            end else if (wr) begin
                pend_d     = wr_div;
                pend_vld_d = 1'b1;
            end
            // At a wrap cnt_d is 0, so the old divisor's LO gives the right answer.
            out_d  = (cnt_d >= W'(lo_of(32'(div_q))));
            rise_d = ~out_q & out_d;
            fall_d = out_q & ~out_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q      <= '0;
            div_q      <= W'(DIV_RST);
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            out_q      <= 1'b0;
            rise_q     <= 1'b0;
            fall_q     <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            out_q      <= out_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
        end
    end

    assign busy    = pend_vld_q;
    assign clk_out = out_q;
    assign rise    = rise_q;
    assign fall    = fall_q;
endmodule

// File: rtl/clk_div_multi.sv
// Multi-channel programmable clock-enable divider: write validation, channel decode,
// and NCH independent divider channels.
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int NCH     = 4,
    parameter int W       = 8,
    parameter int DIV_RST = DIV_RST_DEF,
    localparam int SELW   = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic [NCH-1:0]  EN,
    input  logic            DIV_WR,
    input  logic [SELW-1:0] DIV_SEL,
    input  logic [W-1:0]    DIV_IN,
    output logic [NCH-1:0]  DIV_BUSY,
    output logic            DIV_ERR,
    output logic [NCH-1:0]  CLK_OUT,
    output logic [NCH-1:0]  RISE,
    output logic [NCH-1:0]  FALL
);
    logic wr_ok;
    logic err_q, err_d;

    assign wr_ok = DIV_WR && (DIV_IN >= W'(DIV_MIN)) && (int'(DIV_SEL) < NCH);

    always_comb begin
        err_d = DIV_WR & ~wr_ok;
    end

    always_ff @(posedge CLK) begin
        if (RESET) err_q <= 1'b0;
        else       err_q <= err_d;
    end

    assign DIV_ERR = err_q;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        clk_div_chan #(
            .W       (W),
            .DIV_RST (DIV_RST)
        ) u_ch (
            .CLK     (CLK),
            .RESET   (RESET),
            .en      (EN[i]),
            .wr      (wr_ok && (DIV_SEL == SELW'(i))),
            .wr_div  (DIV_IN),
            .busy    (DIV_BUSY[i]),
            .clk_out (CLK_OUT[i]),
            .rise    (RISE[i]),
            .fall    (FALL[i])
        );
    end
endmodule
